mem_arbiter: RTL and testbench

//  - Shares the single main-memory port between the icache and dcache controllers.
//  - Each cache raises a request; the arbiter grants one by round-robin, issues a line read or

---
 rtl/mem_arbiter_if.sv | 78 +++++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bus bundle between the two cache controllers, the memory model and the
// memory arbiter.
//
// Handshake: a memory request transfers on a cycle where mem_req_valid and
// mem_req_ready are both 1. While mem_req_valid is 1 and mem_req_ready is 0,
// mem_req_addr/data/write hold their values. mem_resp is a 1-cycle strobe
// with no back-pressure. ic_req/dc_req are levels that stay high until the
// matching ic_resp/dc_resp strobe.
//
// Modports:
//   slave  - arbiter side (takes cache requests and memory responses, drives
//            grants, strobes and memory requests)
//   master - environment side (the caches and the memory)
//
// Signals:
//   ic_* / dc_*      request, address, write line and write flag from each
//                    cache; grant and resp back to it
//   mem_req_*        request channel to memory
//   mem_resp*        response channel from memory
//   resp_addr/data   response address/line passed through to both caches
//   timeout_err      sticky flag: a transaction was abandoned
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                  ic_req;
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic [LINE_WIDTH-1:0] ic_data;
    logic                  ic_write;
    logic                  ic_grant;
    logic                  ic_resp;

    logic                  dc_req;
    logic [ADDR_WIDTH-1:0] dc_addr;
    logic [LINE_WIDTH-1:0] dc_data;
    logic                  dc_write;
    logic                  dc_grant;
    logic                  dc_resp;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [LINE_WIDTH-1:0] mem_req_data;
    logic                  mem_req_write;

    logic                  mem_resp;
    logic [ADDR_WIDTH-1:0] mem_resp_addr;
    logic [LINE_WIDTH-1:0] mem_resp_data;

    logic [ADDR_WIDTH-1:0] resp_addr;
    logic [LINE_WIDTH-1:0] resp_data;
    logic                  timeout_err;

    modport slave (
        input  ic_req, ic_addr, ic_data, ic_write,
        output ic_grant, ic_resp,
        input  dc_req, dc_addr, dc_data, dc_write,
        output dc_grant, dc_resp,
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_write,
        input  mem_req_ready,
        input  mem_resp, mem_resp_addr, mem_resp_data,
        output resp_addr, resp_data, timeout_err
    );

    modport master (
        output ic_req, ic_addr, ic_data, ic_write,
        input  ic_grant, ic_resp,
        output dc_req, dc_addr, dc_data, dc_write,
        input  dc_grant, dc_resp,
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_write,
        output mem_req_ready,
        output mem_resp, mem_resp_addr, mem_resp_data,
        input  resp_addr, resp_data, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single main-memory port between the icache and dcache
// controllers. One requester is granted round-robin, its line read or
// eviction write is issued to memory, and the grant is held until the
// response with the matching address returns (so the owner can fill on
// resp & grant) or until the wait times out.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low reset (0 = reset)
//   bus        slave modport of mem_arbiter_if (cache, memory channels)
//   state_dbg  out  current FSM state (0 idle, 1 issue, 2 wait)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                state;
    state_t                state_next;

    logic                  owner_dc;   // 0: icache owns the port, 1: dcache
    logic                  last_dc;    // owner of the most recently finished transaction
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [LINE_WIDTH-1:0] lat_data;
    logic                  lat_write;
    logic [TW-1:0]         timer;
    logic                  timeout_q;

    logic                  load;
    logic                  pick_dc;
    logic                  timer_clr;
    logic                  timer_inc;
    logic                  done;
    logic                  set_timeout;
    logic                  grant_on;
    logic                  req_valid;
    logic                  hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        pick_dc     = 1'b0;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;
        done        = 1'b0;
        set_timeout = 1'b0;
        grant_on    = 1'b0;
        req_valid   = 1'b0;
        hit         = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.ic_req || bus.dc_req) begin
                    // dcache wins when it is alone, or on a tie when the
                    // icache finished last.
                    pick_dc    = bus.dc_req && (!bus.ic_req || !last_dc);
                    load       = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                grant_on  = 1'b1;
                req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    timer_clr  = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                grant_on = 1'b1;
                // Responses for other addresses are stale or foreign; ignore them.
                hit = bus.mem_resp && (bus.mem_resp_addr == lat_addr);
                if (hit) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end else if (timer == TIMER_LAST) begin
                    done        = 1'b1;
                    set_timeout = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_dc  <= 1'b0;
            last_dc   <= 1'b1;   // icache wins the first tie
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_write <= 1'b0;
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (load) begin
                owner_dc  <= pick_dc;
                lat_addr  <= pick_dc ? bus.dc_addr  : bus.ic_addr;
                lat_data  <= pick_dc ? bus.dc_data  : bus.ic_data;
                lat_write <= pick_dc ? bus.dc_write : bus.ic_write;
            end
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + 1'b1;
            end
            if (done) begin
                last_dc <= owner_dc;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.ic_grant      = grant_on && !owner_dc;
    assign bus.dc_grant      = grant_on && owner_dc;
    assign bus.ic_resp       = hit && !owner_dc;
    assign bus.dc_resp       = hit && owner_dc;
    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = lat_addr;
    assign bus.mem_req_data  = lat_data;
    assign bus.mem_req_write = lat_write;
    assign bus.resp_addr     = bus.mem_resp_addr;
    assign bus.resp_data     = bus.mem_resp_data;
    assign bus.timeout_err   = timeout_q;
    assign state_dbg         = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by randomized cache/memory traffic. A
// transaction-level reference model (owner, accepted flag, wait count,
// last owner) predicts every arbiter output each cycle.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
    logic [1:0] state_dbg;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // reference model: 0 = nobody, 1 = icache, 2 = dcache
    int          m_owner;
    bit          m_acc;
    int          m_wait;
    int          m_last;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_data;
    logic        m_write;
    logic        m_tmo;

    // observed values from the latest cycle
    logic obs_icg, obs_dcg, obs_icr, obs_dcr, obs_val, obs_write, obs_tmo;
    logic [AW-1:0] obs_addr;
    logic [LW-1:0] obs_data;
    logic [1:0]    obs_state;
    int n_ic_grant, n_dc_grant, n_ic_resp, n_dc_resp;
    bit ev_accept, ev_ic_resp, ev_dc_resp;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_acc = 1'b0; m_wait = 0; m_last = 2;
        m_addr = '0; m_data = '0; m_write = 1'b0; m_tmo = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, return 1 time unit later so the caller can drive inputs.
    task automatic cycle();
        logic e_hit;
        @(negedge clk);
        e_hit = (m_owner != 0) && m_acc && bus.mem_resp && (bus.mem_resp_addr == m_addr);
        obs_icg = bus.ic_grant;  obs_dcg = bus.dc_grant;
        obs_icr = bus.ic_resp;   obs_dcr = bus.dc_resp;
        obs_val = bus.mem_req_valid; obs_addr = bus.mem_req_addr;
        obs_data = bus.mem_req_data; obs_write = bus.mem_req_write;
        obs_tmo = bus.timeout_err; obs_state = state_dbg;
        n_ic_grant += int'(obs_icg); n_dc_grant += int'(obs_dcg);
        n_ic_resp  += int'(obs_icr); n_dc_resp  += int'(obs_dcr);
        chk1("ic_grant", bus.ic_grant, m_owner == 1);
        chk1("dc_grant", bus.dc_grant, m_owner == 2);
        chk1("grant_onehot", bus.ic_grant & bus.dc_grant, 1'b0);
        chk1("ic_resp", bus.ic_resp, e_hit && m_owner == 1);
        chk1("dc_resp", bus.dc_resp, e_hit && m_owner == 2);
        chk1("mem_req_valid", bus.mem_req_valid, (m_owner != 0) && !m_acc);
        chkw("mem_req_addr", LW'(bus.mem_req_addr), LW'(m_addr));
        chkw("mem_req_data", bus.mem_req_data, m_data);
        chk1("mem_req_write", bus.mem_req_write, m_write);
        chk1("timeout_err", bus.timeout_err, m_tmo);
        chkw("resp_addr", LW'(bus.resp_addr), LW'(bus.mem_resp_addr));
        chkw("resp_data", bus.resp_data, bus.mem_resp_data);
        ev_accept  = reset && (m_owner != 0) && !m_acc && bus.mem_req_ready;
        ev_ic_resp = reset && e_hit && m_owner == 1;
        ev_dc_resp = reset && e_hit && m_owner == 2;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (bus.ic_req || bus.dc_req) begin
                if (bus.ic_req && bus.dc_req) m_owner = (m_last == 1) ? 2 : 1;
                else                          m_owner = bus.ic_req ? 1 : 2;
                m_addr  = (m_owner == 1) ? bus.ic_addr  : bus.dc_addr;
                m_data  = (m_owner == 1) ? bus.ic_data  : bus.dc_data;
                m_write = (m_owner == 1) ? bus.ic_write : bus.dc_write;
                m_acc   = 1'b0;
            end
        end else if (!m_acc) begin
            if (bus.mem_req_ready) begin
                m_acc = 1'b1; m_wait = 0;
            end
        end else if (e_hit) begin
            m_last = m_owner; m_owner = 0;
        end else if (m_wait == TO - 1) begin
            m_tmo = 1'b1; m_last = m_owner; m_owner = 0;
        end else begin
            m_wait++;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_counts();
        n_ic_grant = 0; n_dc_grant = 0; n_ic_resp = 0; n_dc_resp = 0;
    endtask

    task automatic idle_inputs();
        bus.ic_req = 1'b0; bus.ic_addr = '0; bus.ic_data = '0; bus.ic_write = 1'b0;
        bus.dc_req = 1'b0; bus.dc_addr = '0; bus.dc_data = '0; bus.dc_write = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_resp = 1'b0;
        bus.mem_resp_addr = '0; bus.mem_resp_data = '0;
    endtask

    task automatic mem_respond(input logic [AW-1:0] a);
        bus.mem_resp = 1'b1; bus.mem_resp_addr = a;
        bus.mem_resp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // random-phase memory agent state
    bit            pend;
    int            pend_dly;
    logic [AW-1:0] pend_addr;

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_reset();
        clear_counts();
        @(posedge clk); #1;

        // reset state
        run(3);
        chk1("rst_state_idle", obs_state == 2'd0, 1'b1);
        reset = 1'b1;

        // 1: icache read 0x100, response 3 cycles after issue
        clear_counts();
        bus.ic_req = 1'b1; bus.ic_addr = 32'h100; bus.ic_write = 1'b0;
        cycle();
        chk1("t1_no_grant_idle", obs_icg, 1'b0);
        bus.mem_req_ready = 1'b1;
        cycle();
        chk1("t1_grant_t1", obs_icg, 1'b1);
        chk1("t1_valid_t1", obs_val, 1'b1);
        bus.mem_req_ready = 1'b0;
        run(2);
        mem_respond(32'h100);
        cycle();
        chk1("t1_resp", obs_icr, 1'b1);
        chk1("t1_grant_at_resp", obs_icg, 1'b1);
        bus.mem_resp = 1'b0; bus.ic_req = 1'b0;
        cycle();
        chk1("t1_grant_drop", obs_icg, 1'b0);
        chkw("t1_grant_cycles", LW'(n_ic_grant), LW'(4));
        chkw("t1_resp_count", LW'(n_ic_resp), LW'(1));
        chkw("t1_dc_never", LW'(n_dc_grant), LW'(0));

        // 2: simultaneous requests right after reset
        reset = 1'b0; cycle(); reset = 1'b1;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h300;
        bus.dc_req = 1'b1; bus.dc_addr = 32'h400; bus.dc_data = 128'h1234;
        cycle();
        bus.mem_req_ready = 1'b1;
        cycle();
        chk1("t2_ic_first", obs_icg, 1'b1);
        chk1("t2_dc_waits", obs_dcg, 1'b0);
        bus.mem_req_ready = 1'b0;
        mem_respond(32'h300);
        cycle();
        chk1("t2_ic_resp", obs_icr, 1'b1);
        bus.mem_resp = 1'b0; bus.ic_req = 1'b0;
        cycle();
        chk1("t2_dc_not_r1", obs_dcg, 1'b0);
        cycle();
        chk1("t2_dc_at_r2", obs_dcg, 1'b1);
        chkw("t2_dc_addr", LW'(obs_addr), LW'(32'h400));
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.mem_req_ready = 1'b0;
        mem_respond(32'h400);
        cycle();
        chk1("t2_dc_resp", obs_dcr, 1'b1);
        bus.mem_resp = 1'b0; bus.dc_req = 1'b0;
        cycle();

        // 3: dcache eviction under memory back-pressure
        bus.dc_req = 1'b1; bus.dc_addr = 32'h200; bus.dc_write = 1'b1;
        bus.dc_data = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk1("t3_valid_held", obs_val, 1'b1);
            chkw("t3_addr_stable", LW'(obs_addr), LW'(32'h200));
            chkw("t3_data_stable", obs_data, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF);
            chk1("t3_write", obs_write, 1'b1);
        end
        bus.mem_req_ready = 1'b1;
        cycle();
        chk1("t3_valid_on_accept", obs_val, 1'b1);
        bus.mem_req_ready = 1'b0;
        cycle();
        chk1("t3_wait_no_valid", obs_val, 1'b0);
        chk1("t3_wait_grant", obs_dcg, 1'b1);
        mem_respond(32'h200);
        cycle();
        chk1("t3_resp", obs_dcr, 1'b1);
        bus.mem_resp = 1'b0; bus.dc_req = 1'b0; bus.dc_write = 1'b0;
        cycle();

        // 4: mismatched response address is ignored
        bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
        cycle();
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.mem_req_ready = 1'b0;
        mem_respond(32'h140);
        cycle();
        chk1("t4_wrong_addr_no_resp", obs_icr, 1'b0);
        chk1("t4_grant_kept", obs_icg, 1'b1);
        mem_respond(32'h100);
        cycle();
        chk1("t4_resp", obs_icr, 1'b1);
        bus.mem_resp = 1'b0; bus.ic_req = 1'b0;
        cycle();

        // 5: timeout, then the other pending requester is granted
        bus.ic_req = 1'b1; bus.ic_addr = 32'h500;
        cycle();
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.mem_req_ready = 1'b0;
        bus.dc_req = 1'b1; bus.dc_addr = 32'h600;
        run(TO - 1);
        cycle();
        chk1("t5_grant_last_wait", obs_icg, 1'b1);
        chk1("t5_no_tmo_yet", obs_tmo, 1'b0);
        cycle();
        chk1("t5_grant_dropped", obs_icg, 1'b0);
        chk1("t5_tmo_set", obs_tmo, 1'b1);
        cycle();
        chk1("t5_dc_granted", obs_dcg, 1'b1);
        bus.ic_req = 1'b0;
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.mem_req_ready = 1'b0;
        mem_respond(32'h600);
        cycle();
        chk1("t5_dc_resp", obs_dcr, 1'b1);
        bus.mem_resp = 1'b0; bus.dc_req = 1'b0;
        run(3);
        chk1("t5_tmo_sticky", obs_tmo, 1'b1);

        // 6: reset during WAIT, late response ignored
        bus.ic_req = 1'b1; bus.ic_addr = 32'h700;
        cycle();
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.mem_req_ready = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1; bus.ic_req = 1'b0;
        mem_respond(32'h700);
        cycle();
        chk1("t6_grant_cleared", obs_icg, 1'b0);
        chk1("t6_no_late_resp", obs_icr, 1'b0);
        chk1("t6_valid_cleared", obs_val, 1'b0);
        chk1("t6_tmo_cleared", obs_tmo, 1'b0);
        chkw("t6_addr_cleared", LW'(obs_addr), LW'(0));
        chk1("t6_state_idle", obs_state == 2'd0, 1'b1);
        bus.mem_resp = 1'b0;
        cycle();

        // randomized traffic
        pend = 1'b0; pend_dly = 0; pend_addr = '0;
        for (int k = 0; k < 2000; k++) begin
            if (!bus.ic_req && $urandom_range(0, 3) == 0) begin
                bus.ic_req   = 1'b1;
                bus.ic_addr  = $urandom() & 32'hFFFF_FFF0;
                bus.ic_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.ic_write = 1'($urandom_range(0, 1));
            end
            if (!bus.dc_req && $urandom_range(0, 3) == 0) begin
                bus.dc_req   = 1'b1;
                bus.dc_addr  = $urandom() & 32'hFFFF_FFF0;
                bus.dc_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.dc_write = 1'($urandom_range(0, 1));
            end
            bus.mem_req_ready = ($urandom_range(0, 2) != 0);
            bus.mem_resp = 1'b0;
            if (pend && pend_dly == 0) begin
                mem_respond(pend_addr);
                pend = 1'b0;
            end else begin
                if (pend) pend_dly--;
                if ($urandom_range(0, 7) == 0) mem_respond(m_addr ^ 32'h1000_0040);
            end
            cycle();
            if (ev_accept && $urandom_range(0, 15) != 0) begin
                pend = 1'b1; pend_dly = $urandom_range(0, 6); pend_addr = m_addr;
            end
            if (ev_ic_resp) bus.ic_req = 1'b0;
            if (ev_dc_resp) bus.dc_req = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
